// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data-cache controller with registered outputs.
// Optional hit/miss statistics counters are built only when DCACHE_STATS_EN is defined.
module dcache_ctrl #(
    parameter int WORD_W  = 32,
    parameter int BLOCK_W = 128,
    parameter int LINES   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WORD_W-1:0]  cpu_addr,
    input  logic               cpu_rd,
    input  logic               cpu_wr,
    input  logic [WORD_W-1:0]  cpu_wdata,
    output logic [WORD_W-1:0]  cpu_rdata,
    output logic               cpu_ready,
    output logic [WORD_W-1:0]  mem_addr,
    output logic               mem_readable,
    output logic               mem_writable,
    output logic [BLOCK_W-1:0] mem_write,
    input  logic [BLOCK_W-1:0] mem_out1,
    input  logic [BLOCK_W-1:0] mem_out2,
    output logic [31:0]        hit_count,
    output logic [31:0]        miss_count
);

    localparam int OFF_W  = $clog2(BLOCK_W / 8);
    localparam int WSEL_W = $clog2(BLOCK_W / WORD_W);
    localparam int IDX_W  = $clog2(LINES);
    localparam int TAG_W  = WORD_W - IDX_W - OFF_W;
    localparam int BYTE_W = OFF_W - WSEL_W;

    typedef enum logic [2:0] {IDLE, WB, FILL_REQ, FILL_WAIT, RESP} state_t;

    state_t state, state_nxt;

    logic [BLOCK_W-1:0] line_data [LINES];
    logic [TAG_W-1:0]   line_tag  [LINES];
    logic [LINES-1:0]   line_valid;
    logic [LINES-1:0]   line_dirty;

    logic [TAG_W-1:0]   lat_tag;
    logic [IDX_W-1:0]   lat_idx;
    logic [WSEL_W-1:0]  lat_wsel;
    logic [WORD_W-1:0]  lat_wdata;
    logic               lat_store;

    logic [WORD_W-1:0]  cpu_rdata_nxt;
    logic               cpu_ready_nxt;
    logic [WORD_W-1:0]  mem_addr_nxt;
    logic               mem_readable_nxt;
    logic               mem_writable_nxt;
    logic [BLOCK_W-1:0] mem_write_nxt;

    logic [TAG_W-1:0]   req_tag;
    logic [IDX_W-1:0]   req_idx;
    logic [WSEL_W-1:0]  req_wsel;
    logic               req;
    logic               hit;
    logic               idle_req;
    logic               unused_bits;

    // Word 0 sits in the most significant slice of a block (big-endian order).
    function automatic logic [WORD_W-1:0] get_word(input logic [BLOCK_W-1:0] blk,
                                                   input logic [WSEL_W-1:0]  sel);
        return blk[BLOCK_W-1-int'(sel)*WORD_W -: WORD_W];
    endfunction

    function automatic logic [BLOCK_W-1:0] put_word(input logic [BLOCK_W-1:0] blk,
                                                    input logic [WSEL_W-1:0]  sel,
                                                    input logic [WORD_W-1:0]  w);
        logic [BLOCK_W-1:0] r;
        r = blk;
        r[BLOCK_W-1-int'(sel)*WORD_W -: WORD_W] = w;
        return r;
    endfunction

    assign req_tag     = cpu_addr[WORD_W-1 -: TAG_W];
    assign req_idx     = cpu_addr[OFF_W +: IDX_W];
    assign req_wsel    = cpu_addr[OFF_W-1 -: WSEL_W];
    assign req         = cpu_rd | cpu_wr;
    assign hit         = line_valid[req_idx] && (line_tag[req_idx] == req_tag);
    assign idle_req    = (state == IDLE) && req;
    assign unused_bits = ^{mem_out2, cpu_addr[BYTE_W-1:0]};

    always_comb begin
        state_nxt        = state;
        cpu_rdata_nxt    = '0;
        cpu_ready_nxt    = 1'b0;
        mem_addr_nxt     = '0;
        mem_readable_nxt = 1'b0;
        mem_writable_nxt = 1'b0;
        mem_write_nxt    = '0;
        case (state)
            IDLE: begin
                if (req) begin
                    if (hit) begin
                        cpu_ready_nxt = 1'b1;
                        cpu_rdata_nxt = cpu_wr ? cpu_wdata : get_word(line_data[req_idx], req_wsel);
                    end else if (line_valid[req_idx] && line_dirty[req_idx]) begin
                        state_nxt        = WB;
                        mem_writable_nxt = 1'b1;
                        mem_addr_nxt     = {line_tag[req_idx], req_idx, {OFF_W{1'b0}}};
                        mem_write_nxt    = line_data[req_idx];
                    end else begin
                        state_nxt        = FILL_REQ;
                        mem_readable_nxt = 1'b1;
                        mem_addr_nxt     = {req_tag, req_idx, {OFF_W{1'b0}}};
                    end
                end
            end
            WB: begin
                state_nxt        = FILL_REQ;
                mem_readable_nxt = 1'b1;
                mem_addr_nxt     = {lat_tag, lat_idx, {OFF_W{1'b0}}};
            end
            FILL_REQ: state_nxt = FILL_WAIT;
            FILL_WAIT: begin
                state_nxt     = RESP;
                cpu_ready_nxt = 1'b1;
                cpu_rdata_nxt = lat_store ? lat_wdata : get_word(mem_out1, lat_wsel);
            end
            RESP: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            line_valid   <= '0;
            line_dirty   <= '0;
            cpu_rdata    <= '0;
            cpu_ready    <= 1'b0;
            mem_addr     <= '0;
            mem_readable <= 1'b0;
            mem_writable <= 1'b0;
            mem_write    <= '0;
        end else begin
            state        <= state_nxt;
            cpu_rdata    <= cpu_rdata_nxt;
            cpu_ready    <= cpu_ready_nxt;
            mem_addr     <= mem_addr_nxt;
            mem_readable <= mem_readable_nxt;
            mem_writable <= mem_writable_nxt;
            mem_write    <= mem_write_nxt;
            if (idle_req && hit && cpu_wr)
                line_dirty[req_idx] <= 1'b1;
            if (state == WB)
                line_dirty[lat_idx] <= 1'b0;
            if (state == FILL_WAIT) begin
                line_valid[lat_idx] <= 1'b1;
                line_dirty[lat_idx] <= lat_store;
            end
        end
    end

    // Line storage and request latches carry no reset; valid bits guard them.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (idle_req && hit && cpu_wr)
                line_data[req_idx] <= put_word(line_data[req_idx], req_wsel, cpu_wdata);
            if (state == FILL_WAIT) begin
                line_data[lat_idx] <= lat_store ? put_word(mem_out1, lat_wsel, lat_wdata) : mem_out1;
                line_tag[lat_idx]  <= lat_tag;
            end
        end
        if (idle_req) begin
            lat_tag   <= req_tag;
            lat_idx   <= req_idx;
            lat_wsel  <= req_wsel;
            lat_wdata <= cpu_wdata;
            lat_store <= cpu_wr;
        end
    end

`ifdef DCACHE_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (idle_req) begin
            if (hit)
                hit_count <= hit_count + 32'd1;
            else
                miss_count <= miss_count + 32'd1;
        end
    end
`else
    assign hit_count  = '0;
    assign miss_count = '0;
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Scoreboard bench for dcache_ctrl: block-memory model, shadow word memory, timing checks.
module tb_dcache_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  cpu_addr;
    logic         cpu_rd;
    logic         cpu_wr;
    logic [31:0]  cpu_wdata;
    logic [31:0]  cpu_rdata;
    logic         cpu_ready;
    logic [31:0]  mem_addr;
    logic         mem_readable;
    logic         mem_writable;
    logic [127:0] mem_write;
    logic [127:0] mem_out1;
    logic [127:0] mem_out2;
    logic [31:0]  hit_count;
    logic [31:0]  miss_count;

    always #5 clk = ~clk;

    dcache_ctrl dut (
        .clk(clk), .rst(rst),
        .cpu_addr(cpu_addr), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
        .mem_addr(mem_addr), .mem_readable(mem_readable), .mem_writable(mem_writable),
        .mem_write(mem_write), .mem_out1(mem_out1), .mem_out2(mem_out2),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int e_hit    = 0;
    int e_miss   = 0;

    logic [127:0] mem_arr [256];
    logic [31:0]  shadow  [1024];
    logic [31:0]  sb_q    [$];

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] blk_init(input int b);
        logic [31:0] base;
        base = 32'hA000_0000 + 32'(b << 4);
        return {base, base + 32'd1, base + 32'd2, base + 32'd3};
    endfunction

    task automatic sync_shadow();
        for (int b = 0; b < 256; b++)
            for (int k = 0; k < 4; k++)
                shadow[b*4+k] = mem_arr[b][127-32*k -: 32];
    endtask

    // Block memory: one-cycle read latency, write commits on the strobe edge.
    always @(posedge clk) begin
        if (mem_writable)
            mem_arr[mem_addr[11:4]] <= mem_write;
        if (mem_readable)
            mem_out1 <= mem_arr[mem_addr[11:4]];
    end

    always @(negedge clk) begin
        if (!rst && cpu_ready) begin
            if (sb_q.size() == 0)
                chk("unexpected_ready", 128'd1, 128'd0);
            else
                chk("rdata", 128'(cpu_rdata), 128'(sb_q.pop_front()));
        end
    end

    task automatic check_stats(input string tag);
`ifdef DCACHE_STATS_EN
        chk({tag, "_hit_count"}, 128'(hit_count), 128'(e_hit));
        chk({tag, "_miss_count"}, 128'(miss_count), 128'(e_miss));
`else
        chk({tag, "_hit_count"}, 128'(hit_count), 128'd0);
        chk({tag, "_miss_count"}, 128'(miss_count), 128'd0);
`endif
    endtask

    // exp_wb / exp_fill give the cycle of the expected strobe, 0 meaning none.
    task automatic access(input string tag, input logic wr, input logic rd,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input int exp_lat, input int exp_wb, input logic [31:0] wb_addr,
                          input logic [127:0] wb_data, input int exp_fill,
                          input logic [31:0] fill_addr);
        int n, rd_c, wr_c;
        logic both, done;
        logic [31:0] rd_a, wr_a;
        logic [127:0] wr_d;
        n = 0; rd_c = 0; wr_c = 0; both = 1'b0; done = 1'b0;
        rd_a = '0; wr_a = '0; wr_d = '0;
        @(negedge clk);
        if (wr) begin
            shadow[addr[11:2]] = wdata;
            sb_q.push_back(wdata);
        end else begin
            sb_q.push_back(shadow[addr[11:2]]);
        end
        cpu_addr = addr; cpu_wr = wr; cpu_rd = rd; cpu_wdata = wdata;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
            if (mem_readable && rd_c == 0) begin rd_c = n; rd_a = mem_addr; end
            if (mem_writable && wr_c == 0) begin wr_c = n; wr_a = mem_addr; wr_d = mem_write; end
            if (mem_readable && mem_writable) both = 1'b1;
            if (cpu_ready) begin
                done = 1'b1;
                cpu_rd = 1'b0;
                cpu_wr = 1'b0;
            end
        end
        if (!done) begin
            cpu_rd = 1'b0;
            cpu_wr = 1'b0;
            if (sb_q.size() > 0) void'(sb_q.pop_back());
        end
        chk({tag, "_latency"}, done ? 128'(n) : 128'hFFFF, 128'(exp_lat));
        chk({tag, "_wb_cycle"}, 128'(wr_c), 128'(exp_wb));
        chk({tag, "_fill_cycle"}, 128'(rd_c), 128'(exp_fill));
        if (exp_wb != 0) begin
            chk({tag, "_wb_addr"}, 128'(wr_a), 128'(wb_addr));
            chk({tag, "_wb_data"}, wr_d, wb_data);
        end
        if (exp_fill != 0)
            chk({tag, "_fill_addr"}, 128'(rd_a), 128'(fill_addr));
        chk({tag, "_strobe_overlap"}, 128'(both), 128'd0);
        if (exp_lat == 1) e_hit++; else e_miss++;
        check_stats(tag);
    endtask

    initial begin
        for (int b = 0; b < 256; b++) mem_arr[b] = blk_init(b);
        mem_arr[1] = 128'h11111111_22222222_33333333_44444444;
        sync_shadow();
        mem_out1 = '0; mem_out2 = {4{32'h5A5A_5A5A}};
        rst = 1'b1; cpu_addr = '0; cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_wdata = '0;

        repeat (3) @(negedge clk);
        chk("reset_ready", 128'(cpu_ready), 128'd0);
        chk("reset_rdata", 128'(cpu_rdata), 128'd0);
        chk("reset_mem_rd", 128'(mem_readable), 128'd0);
        chk("reset_mem_wr", 128'(mem_writable), 128'd0);
        chk("reset_mem_write", mem_write, 128'd0);
        chk("reset_mem_addr", 128'(mem_addr), 128'd0);
        check_stats("reset");
        rst = 1'b0;

        access("ld10_miss", 1'b0, 1'b1, 32'h10, 32'h0, 3, 0, 32'h0, 128'h0, 1, 32'h10);
        access("ld14_hit", 1'b0, 1'b1, 32'h14, 32'h0, 1, 0, 32'h0, 128'h0, 0, 32'h0);
        access("st18_hit", 1'b1, 1'b0, 32'h18, 32'hDEADBEEF, 1, 0, 32'h0, 128'h0, 0, 32'h0);
        access("ld118_dirty", 1'b0, 1'b1, 32'h118, 32'h0, 4, 1, 32'h10,
               128'h11111111_22222222_DEADBEEF_44444444, 2, 32'h110);
        chk("wb_committed", mem_arr[1], 128'h11111111_22222222_DEADBEEF_44444444);
        access("st20c_miss", 1'b1, 1'b0, 32'h20C, 32'hCAFEF00D, 3, 0, 32'h0, 128'h0, 1, 32'h200);
        access("ld20c_hit", 1'b0, 1'b1, 32'h20C, 32'h0, 1, 0, 32'h0, 128'h0, 0, 32'h0);
        access("rdwr30", 1'b1, 1'b1, 32'h30, 32'h12345678, 3, 0, 32'h0, 128'h0, 1, 32'h30);
        access("ld130_dirty", 1'b0, 1'b1, 32'h130, 32'h0, 4, 1, 32'h30,
               {32'h12345678, 32'hA0000031, 32'hA0000032, 32'hA0000033}, 2, 32'h130);

        // Abort a fill by resetting while the controller waits for the block.
        @(negedge clk);
        cpu_addr = 32'h40; cpu_rd = 1'b1;
        @(negedge clk);
        chk("abort_fill_strobe", 128'(mem_readable), 128'd1);
        @(negedge clk);
        rst = 1'b1; cpu_rd = 1'b0;
        @(negedge clk);
        chk("abort_no_ready", 128'(cpu_ready), 128'd0);
        chk("abort_no_strobe", 128'(mem_readable), 128'd0);
        e_hit = 0; e_miss = 0;
        check_stats("abort");
        rst = 1'b0;
        @(negedge clk);
        chk("abort_idle_ready", 128'(cpu_ready), 128'd0);
        sync_shadow();

        access("ld40_retry", 1'b0, 1'b1, 32'h40, 32'h0, 3, 0, 32'h0, 128'h0, 1, 32'h40);
        access("ld14_after_rst", 1'b0, 1'b1, 32'h14, 32'h0, 3, 0, 32'h0, 128'h0, 1, 32'h10);
        access("ld18_after_rst", 1'b0, 1'b1, 32'h18, 32'h0, 1, 0, 32'h0, 128'h0, 0, 32'h0);
        chk("ld18_value", 128'(shadow[32'h18 >> 2]), 128'(32'hDEADBEEF));

        repeat (2) @(negedge clk);
        chk("scoreboard_empty", 128'(sb_q.size()), 128'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dcache_ctrl.md
# dcache_ctrl

Direct-mapped, write-back, write-allocate data-cache controller between the CPU load/store port and the block-oriented data memory. Issues block reads and writes to the data memory (initiator side), holds `LINES` block-sized lines with tag/valid/dirty state and serves word accesses from them. Sits in the MEM stage and stalls the pipeline through `cpu_ready`.

## Interface
- `WORD_W`, 32, CPU word width in bits.
- `BLOCK_W`, 128, line width in bits. Equals the memory block width.
- `LINES`, 16, number of lines. Power of two.

Reset is synchronous and active-high.
- `clk` input 1: single clock. All state changes on the posedge.
- `rst` input 1: synchronous, active-high reset.
- `cpu_addr` input WORD_W: byte address. Bits [1:0] are ignored.
- `cpu_rd` input 1: load request. Sampled only in IDLE.
- `cpu_wr` input 1: store request. Sampled only in IDLE. Has priority over `cpu_rd`.
- `cpu_wdata` input WORD_W: store data.
- `cpu_rdata` output WORD_W: load data. Valid while `cpu_ready` is high.
- `cpu_ready` output 1: one-cycle completion pulse.
- `mem_addr` output WORD_W: block-aligned byte address. The low log2(BLOCK_W/8) bits are 0.
- `mem_readable` output 1: block read strobe.
- `mem_writable` output 1: block write strobe.
- `mem_write` output BLOCK_W: writeback block.
- `mem_out1` input BLOCK_W: block returned by the memory.
- `mem_out2` input BLOCK_W: next-block prefetch. Ignored by this block.
- `hit_count` output 32: statistics counter (see Configuration).
- `miss_count` output 32: statistics counter (see Configuration).

## Operation
- Address split, shown for the defaults:
  - tag = addr[31:8]
  - index = addr[7:4]
  - word = addr[3:2]
  - General case: word field width is log2(BLOCK_W/WORD_W), index field width is log2(LINES).
- Block byte order is big-endian. Word 0 occupies bits [BLOCK_W-1 -: WORD_W]; word k occupies bits [BLOCK_W-1-k*WORD_W -: WORD_W].
- FSM states: IDLE, WB, FILL_REQ, FILL_WAIT, RESP.
- IDLE: on `cpu_rd` or `cpu_wr`, latch the address, data and op, then look up the line.
  - Hit: complete the access in the same cycle and pulse `cpu_ready` next cycle. A store merges its word into the line and sets dirty. Stay in IDLE.
  - Miss with the victim valid and dirty: go to WB.
  - Miss otherwise: go to FILL_REQ.
- WB: drive `mem_writable`=1, `mem_addr`={victim tag, index, 0} and `mem_write`=victim line for exactly one cycle. Clear dirty, then go to FILL_REQ.
- FILL_REQ: drive `mem_readable`=1 and `mem_addr`={latched tag, index, 0} for one cycle, then go to FILL_WAIT.
- FILL_WAIT: capture `mem_out1` into the line. Set valid and the tag. For a store, merge the store word and set dirty; otherwise clear dirty. Go to RESP.
- RESP: pulse `cpu_ready` with `cpu_rdata` = the requested word (for a store, `cpu_rdata` = the stored word), then go to IDLE. New requests are accepted only in IDLE.
- CPU inputs are ignored outside IDLE. The CPU holds its request until `cpu_ready`, so re-sampling in IDLE after RESP treats the held request as new. The CPU therefore drops `cpu_rd`/`cpu_wr` in the `cpu_ready` cycle.
- Reset:
  - Clears all valid and dirty bits and sets the state to IDLE.
  - All outputs go to 0, including the counters.
  - Line data is not cleared.
  - Reset mid-operation aborts the operation: a WB write already presented to memory has committed, and a pending fill is discarded with no `cpu_ready`.

## Timing
- Request sampled at edge 0, in IDLE.
- Hit: `cpu_ready`=1 in cycle 1. No memory strobes.
- Clean miss: `mem_readable` in cycle 1, capture in cycle 2, `cpu_ready` in cycle 3.
- Dirty miss: `mem_writable` in cycle 1, `mem_readable` in cycle 2, `cpu_ready` in cycle 4.
- Memory read latency is one cycle: data strobed in cycle N is read from `mem_out1` in cycle N+1. A memory write commits on the strobe edge.
- `mem_readable` and `mem_writable` are never high in the same cycle.
- All outputs are registered. `mem_write` is 0 outside WB.

## Configuration
- `DCACHE_STATS_EN` defined:
  - `hit_count` increments on each IDLE hit.
  - `miss_count` increments on each IDLE miss.
  - Both are 32-bit, wrap modulo 2^32, and clear on `rst`.
- Not defined: both outputs are tied to 0 and no counter logic is present.

## Test plan
- Reset, then load 0x10 with memory block 0x11111111_22222222_33333333_44444444 → `mem_readable` with `mem_addr`=0x10 in cycle 1; `cpu_ready` in cycle 3 with `cpu_rdata`=0x11111111; `miss_count`=1 (stats build).
- Load 0x14 → `cpu_ready` in cycle 1, `cpu_rdata`=0x22222222, no memory strobe, `hit_count`=1.
- Store 0xDEADBEEF to 0x18 (hit), then load 0x118 → `mem_writable` in cycle 1 with `mem_addr`=0x10 and `mem_write`=0x11111111_22222222_DEADBEEF_44444444; `mem_readable` with `mem_addr`=0x110 in cycle 2; `cpu_ready` in cycle 4.
- Store 0xCAFEF00D to 0x20C (clean miss) → fill from 0x200; `cpu_ready` in cycle 3; a following load of 0x20C hits and returns 0xCAFEF00D.
- `cpu_rd` and `cpu_wr` both high at 0x30 → treated as a store, and the line becomes dirty.
- Assert `rst` in FILL_WAIT → next cycle is IDLE with no `cpu_ready`; the same load then misses again and issues a new `mem_readable`.
